// File: rtl/rice_symbol_assembler_if.sv
// Bundles the configuration, sample-input and block-output handshakes of
// rice_symbol_assembler, plus a read-only view of its FSM state.
//
// Parameters: J_MAX (max samples per block), SAMPLE_W (bits per sample).
// Signals:
//   cfg_start/cfg_ready  start a block with cfg_j / cfg_k / cfg_mode; cfg_err pulses on a rejected start
//   in_valid/in_ready    one sample per transfer: in_fs (FS value), in_kbits (split bits)
//   out_valid/out_ready  one block per transfer: out_j (sample count), out_block (slot 0 in MSBs), ovf
//   dbg_state            current FSM state (0 IDLE, 1 COLLECT, 2 ZERO, 3 DONE)
//
// Handshake rule for all three channels: a transfer happens on a rising clock
// edge where valid and ready are both high; the source holds its payload
// stable while valid is high and ready is low, and ready never depends
// combinationally on valid.
interface rice_symbol_assembler_if #(
  parameter int J_MAX    = 32,
  parameter int SAMPLE_W = 10,
  parameter int J_W      = $clog2(J_MAX + 1),
  parameter int K_W      = $clog2(SAMPLE_W)
);
  logic                      cfg_start;
  logic                      cfg_ready;
  logic [J_W-1:0]            cfg_j;
  logic [K_W-1:0]            cfg_k;
  logic [1:0]                cfg_mode;
  logic                      cfg_err;
  logic                      in_valid;
  logic                      in_ready;
  logic [SAMPLE_W-1:0]       in_fs;
  logic [SAMPLE_W-1:0]       in_kbits;
  logic                      out_valid;
  logic                      out_ready;
  logic [J_W-1:0]            out_j;
  logic [J_MAX*SAMPLE_W-1:0] out_block;
  logic                      ovf;
  logic [1:0]                dbg_state;

  // Upstream decoders, configuration source and downstream consumer side.
  modport master (
    output cfg_start, cfg_j, cfg_k, cfg_mode, in_valid, in_fs, in_kbits, out_ready,
    input  cfg_ready, cfg_err, in_ready, out_valid, out_j, out_block, ovf, dbg_state
  );

  // Assembler side.
  modport slave (
    input  cfg_start, cfg_j, cfg_k, cfg_mode, in_valid, in_fs, in_kbits, out_ready,
    output cfg_ready, cfg_err, in_ready, out_valid, out_j, out_block, ovf, dbg_state
  );
endinterface

// File: rtl/rice_symbol_assembler.sv
// Rice symbol assembler: rebuilds samples as (fs << k) | kbits from the FS and
// split-bit decoders, collects one block of up to J_MAX samples and hands the
// block downstream as one packed bus (slot 0 in the MSBs, unused slots zero).
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    rice_symbol_assembler_if.slave (cfg / in / out handshakes, ovf, dbg_state)
//
// Block modes (cfg_mode): 00 rice-split, 01 zero-block, 10 uncompressed, 11 rejected.
//
// Optional build macro: RICE_SYM_OVF_EN enables the sticky per-block overflow
// flag (set when fs << k loses bits above SAMPLE_W in rice-split mode). When it
// is undefined, ovf is tied low and no overflow logic exists.
module rice_symbol_assembler #(
  parameter int J_MAX    = 32,
  parameter int SAMPLE_W = 10,
  parameter int J_W      = $clog2(J_MAX + 1),
  parameter int K_W      = $clog2(SAMPLE_W)
) (
  input  logic                     clk,
  input  logic                     reset,
  rice_symbol_assembler_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ZERO    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                    state;
  logic [J_W-1:0]            j_q;
  logic [J_W-1:0]            idx;
  logic [K_W-1:0]            k_q;
  logic                      raw_q;        // 1: uncompressed block, slot = kbits
  logic [J_MAX*SAMPLE_W-1:0] block_q;
  logic                      out_valid_q;
  logic                      cfg_err_q;

  logic                      cfg_legal;
  logic                      accept;
  logic                      last;
  logic [SAMPLE_W-1:0]       shifted;
  logic [SAMPLE_W-1:0]       kmask;
  logic [SAMPLE_W-1:0]       slot_c;

  always_comb begin
    cfg_legal = (bus.cfg_j != '0) &&
                (int'(bus.cfg_j) <= J_MAX) &&
                (int'(bus.cfg_k) < SAMPLE_W) &&
                (bus.cfg_mode != 2'b11);
  end

  assign accept = (state == COLLECT) && bus.in_valid;
  assign last   = (idx == j_q - 1'b1);

`ifdef RICE_SYM_OVF_EN
  logic [2*SAMPLE_W-1:0] wide;
  logic                  ovf_hit;
  logic                  ovf_q;

  // Shift in double width so the bits that fall off the sample are visible.
  always_comb begin
    wide    = {{SAMPLE_W{1'b0}}, bus.in_fs} << k_q;
    shifted = wide[SAMPLE_W-1:0];
    ovf_hit = |wide[2*SAMPLE_W-1:SAMPLE_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (state == IDLE && bus.cfg_start && cfg_legal) begin
      ovf_q <= 1'b0;
    end else if (accept && !raw_q && ovf_hit) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
`else
  always_comb begin
    shifted = bus.in_fs << k_q;
  end

  assign bus.ovf = 1'b0;
`endif

  // k is always < SAMPLE_W, so this mask keeps exactly the low k split bits.
  always_comb begin
    kmask  = ~({SAMPLE_W{1'b1}} << k_q);
    slot_c = raw_q ? bus.in_kbits : (shifted | (bus.in_kbits & kmask));
  end

  // out_valid rises one edge after DONE is entered, so a block is presented
  // one cycle after its last sample and two cycles after a zero-block start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      j_q         <= '0;
      idx         <= '0;
      k_q         <= '0;
      raw_q       <= 1'b0;
      block_q     <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_start) begin
            if (cfg_legal) begin
              j_q     <= bus.cfg_j;
              k_q     <= bus.cfg_k;
              raw_q   <= bus.cfg_mode[1];
              block_q <= '0;
              idx     <= '0;
              state   <= (bus.cfg_mode == 2'b01) ? ZERO : COLLECT;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            for (int s = 0; s < J_MAX; s++) begin
              if (idx == J_W'(s)) begin
                block_q[(J_MAX-1-s)*SAMPLE_W +: SAMPLE_W] <= slot_c;
              end
            end
            idx <= idx + 1'b1;
            if (last) begin
              state <= DONE;
            end
          end
        end
        ZERO: begin
          state <= DONE;
        end
        DONE: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready = (state == IDLE);
  assign bus.in_ready  = (state == COLLECT);
  assign bus.out_valid = out_valid_q;
  assign bus.out_j     = j_q;
  assign bus.out_block = block_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.dbg_state = state;

endmodule
